mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store unit between the single-cycle MIPS datapath (ALU address, rt data) and the word-wide data memory.
//   Performs LW/LH/LHU/LB/LBU/SW/SH/SB on a word-only memory.
//   Sub-word loads: lane extract plus sign/zero extension.
//   Sub-word stores: read-modify-write sequence. busy stalls the core while the access is in progress.
// PARAMETERS
//   ADDR_W  16  byte-address width, equal to the memory addr width; the memory decodes addr[9:2].
// PORTS
//   clock      in   1       single clock; all state updates on posedge
//   rst        in   1       asynchronous, active-low reset
//   req        in   1       one-cycle access request from core; sampled only in IDLE
//   we         in   1       1 = store, 0 = load
//   size       in   2       SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10; 11 is treated as SZ_WORD
//   uns        in   1       loads only: 1 = zero-extend, 0 = sign-extend
//   addr       in   ADDR_W  byte address
//   wdata      in   32      store data, right-aligned
//   rdata      out  32      load result; held until the next load completes
//   busy       out  1       state != IDLE
//   done       out  1       one-cycle pulse when the access completes
//   err        out  1       misaligned access; valid with done
//   mem_addr   out  ADDR_W  word-aligned address to memory (addr[1:0] forced to 00)
//   mem_wdata  out  32      merged write word
//   mem_rdata  in   32      combinational read data from memory
//   mem_read   out  1       memory read enable
//   mem_write  out  1       memory write enable; memory writes on the posedge while high
// BEHAVIOUR
//   Little-endian lanes:
//     - byte lane = addr[1:0], lane 0 = bits [7:0]
//     - halfword lane = addr[1]
//   On accept in IDLE, latch we/size/uns/addr/wdata; the core holds nothing afterwards.
//   FSM states: IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP.
//     - IDLE --req & load--> LOAD --> RESP.
//         LOAD: mem_read=1; extended lane is registered into rdata. done in cycle 2 after req (req = cycle 0).
//     - IDLE --req & SW--> ST_WORD --> RESP.
//         ST_WORD: mem_write=1, mem_wdata = latched wdata. done in cycle 2.
//     - IDLE --req & SH/SB--> RMW_RD --> RMW_WR --> RESP.
//         RMW_RD: mem_read=1; mem_rdata captured into a merge register.
//         RMW_WR: mem_write=1; merge register with the target lane replaced by wdata[7:0]/[15:0]. done in cycle 3.
//     - RESP: done=1, busy=1, then return to IDLE. req in RESP is ignored.
//   Back-to-back: req in the IDLE cycle right after RESP is accepted.
//   mem_read/mem_write/mem_addr/mem_wdata are decoded from state and latched registers only, never from live inputs.
//   Reset (rst=0, any state, any time):
//     - state=IDLE; rdata=0; done=err=busy=0; mem_read=mem_write=0 immediately.
//     - mem_addr=mem_wdata=0.
//     - An interrupted RMW never writes; the memory word is unchanged.
//   Stores leave rdata unchanged.
// CONFIGURATION
//   Macro LSU_MISALIGN_TRAP_EN.
//   Defined:
//     - halfword with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> RESP.
//     - No mem_read/mem_write; done=err=1 in cycle 1; rdata unchanged.
//   Undefined:
//     - err is tied 0.
//     - Misaligned low bits are ignored: halfword uses lane addr[1]; word uses the aligned word.
// STRUCTURE
//   Package mips_mem_pkg:
//     - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//     - FSM state typedef/localparams
//     - lane-index helper constants
//   Sub-module mem_lane_mux (combinational):
//     - load extract plus sign/zero extend
//     - store merge of a lane into a 32-bit word
//   The FSM and registers live in mem_access_unit.
// TESTING
//   1) Release rst after 3 cycles -> rdata=0, busy=done=err=0, mem_read=mem_write=0.
//   2) SW 0xDEADBEEF @0x0010, then LW @0x0010 -> mem_write for exactly 1 cycle;
//      LW done in cycle 2 with rdata=0xDEADBEEF.
//   3) Word @0x0010 = 0x11223344, SB 0xAA @0x0011 -> word = 0x1122AA44, done in cycle 3.
//      LB @0x0011 -> 0xFFFFFFAA; LBU @0x0011 -> 0x000000AA.
//   4) Continuing from 3: SH 0x8001 @0x0012 -> word = 0x8001AA44.
//      LH @0x0012 -> 0xFFFF8001; LHU @0x0012 -> 0x00008001.
//   5) LW @0x0013:
//      - with LSU_MISALIGN_TRAP_EN: done=err=1 in cycle 1, no memory enables.
//      - without: rdata = word @0x0010, err=0.
//   6) Drive rst low during RMW_RD of SB @0x0010 -> mem_write never asserts, word unchanged, busy=0.
//      A req in the RESP cycle is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size encodings, FSM states and lane helpers shared by
// the load/store unit and its lane mux.
package mips_mem_pkg;

  // Access size encodings; 2'b11 behaves as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Load/store sequencing states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ST_WORD = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_WR  = 3'd4,
    S_RESP    = 3'd5
  } lsu_state_t;

  // Lane helpers: a byte lane is addr[1:0], a halfword lane is addr[1].
  localparam int          BYTE_LANE_W   = 2;
  localparam int          HALF_LANE_BIT = 1;
  localparam logic [31:0] BYTE_MASK     = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK     = 32'h0000_FFFF;

  // Word accesses are SZ_WORD and the otherwise unused 2'b11 code.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: combinational lane handling for sub-word accesses.
// Extracts and extends a byte/halfword for loads and merges a store lane
// into a full memory word for read-modify-write stores.
module mem_lane_mux
  import mips_mem_pkg::*;
(
  input  logic [1:0]             size,
  input  logic                   uns,
  input  logic [BYTE_LANE_W-1:0] lane,
  input  logic [31:0]            word,
  input  logic [31:0]            wdata,
  output logic [31:0]            load_val,
  output logic [31:0]            merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane select, load extension and store merge by access size.
  always_comb begin
    byte_sh   = {lane, 3'b000};
    half_sh   = {lane[HALF_LANE_BIT], 4'b0000};
    lane_byte = 8'(word >> byte_sh);
    lane_half = 16'(word >> half_sh);
    load_val  = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_val = uns ? {24'h00_0000, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        merged   = (word & ~(BYTE_MASK << byte_sh)) | ((wdata & BYTE_MASK) << byte_sh);
      end
      SZ_HALF: begin
        load_val = uns ? {16'h0000, lane_half} : {{16{lane_half[15]}}, lane_half};
        merged   = (word & ~(HALF_MASK << half_sh)) | ((wdata & HALF_MASK) << half_sh);
      end
      default: begin
        // SZ_WORD and 2'b11: whole word passes through.
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MIPS datapath and a word-only
// data memory. Sub-word stores use a read-modify-write sequence.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses skip memory and complete with err=1; when undefined, the
// misaligned low address bits are ignored and err stays 0.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  lsu_state_t             state;
  logic [1:0]             lat_size;
  logic                   lat_uns;
  logic [BYTE_LANE_W-1:0] lat_lane;
  logic [31:0]            lat_wdata;
  logic [31:0]            load_val;
  logic [31:0]            merged;
  logic                   trap;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((size == SZ_HALF) && addr[0]) ||
                (is_word(size) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  mem_lane_mux u_lane_mux (
    .size     (lat_size),
    .uns      (lat_uns),
    .lane     (lat_lane),
    .word     (mem_rdata),
    .wdata    (lat_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  // Access sequencer: latches the request and drives all outputs from registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      lat_size  <= SZ_BYTE;
      lat_uns   <= 1'b0;
      lat_lane  <= {BYTE_LANE_W{1'b0}};
      lat_wdata <= 32'h0000_0000;
      rdata     <= 32'h0000_0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 32'h0000_0000;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_size  <= size;
            lat_uns   <= uns;
            lat_lane  <= addr[1:0];
            lat_wdata <= wdata;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            busy      <= 1'b1;
            if (trap) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!we) begin
              state    <= S_LOAD;
              mem_read <= 1'b1;
            end else if (is_word(size)) begin
              state     <= S_ST_WORD;
              mem_write <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state    <= S_RMW_RD;
              mem_read <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_LOAD: begin
          rdata <= load_val;
          state <= S_RESP;
          done  <= 1'b1;
        end
        S_ST_WORD: begin
          state <= S_RESP;
          done  <= 1'b1;
        end
        S_RMW_RD: begin
          mem_wdata <= merged;
          mem_write <= 1'b1;
          state     <= S_RMW_WR;
        end
        S_RMW_WR: begin
          state <= S_RESP;
          done  <= 1'b1;
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, multi-cycle corner sequences and
// randomized accesses checked against a byte-addressed reference memory.
module tb_mem_access_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        uns   = 1'b0;
  logic [15:0] addr  = 16'h0000;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        busy, done, err, mem_read, mem_write;

  logic [31:0] tb_mem  [256]  = '{default: 32'h0};
  logic [7:0]  ref_mem [1024] = '{default: 8'h00};
  logic [31:0] rdata_model = 32'h0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] r;
    logic        e;
    int          c;
  } vec_t;
  vec_t tbl [$];

  mem_access_unit #(.ADDR_W(16)) dut (
    .clock(clock), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clock = ~clock;

  // Word-only data memory: combinational read, write on posedge.
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clock) if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit trap_of(input logic [1:0] sz, input logic [15:0] a);
    if (!TRAP) return 1'b0;
    if (sz == 2'b01) return a[0];
    if (sz[1]) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [15:0] a);
    int i;
    logic [31:0] v;
    i = int'(a[9:0]);
    if (sz == 2'b00) begin
      v = {24'h0, ref_mem[i]};
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      i = i - (i % 2);
      v = {16'h0, ref_mem[i+1], ref_mem[i]};
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      i = i - (i % 4);
      v = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [15:0] a, input logic [31:0] d);
    int i;
    i = int'(a[9:0]);
    if (sz == 2'b00) begin
      ref_mem[i] = d[7:0];
    end else if (sz == 2'b01) begin
      i = i - (i % 2);
      ref_mem[i] = d[7:0]; ref_mem[i+1] = d[15:8];
    end else begin
      i = i - (i % 4);
      ref_mem[i] = d[7:0]; ref_mem[i+1] = d[15:8];
      ref_mem[i+2] = d[23:16]; ref_mem[i+3] = d[31:24];
    end
  endtask

  // One access: starts at a negedge in IDLE, returns at the negedge of the following IDLE cycle.
  task automatic do_access(input string name, input logic w, input logic [1:0] sz, input logic u,
                           input logic [15:0] a, input logic [31:0] d,
                           input logic [31:0] exp_r, input logic exp_e, input int exp_c);
    int cyc, nrd, nwr, exp_rd, exp_wr;
    bit addr_ok, busy_ok, trap, fin;
    trap   = trap_of(sz, a);
    exp_rd = (!trap && (!w || !sz[1])) ? 1 : 0;
    exp_wr = (!trap && w) ? 1 : 0;
    if (w && !trap) ref_store(sz, a, d);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(negedge clock);
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = 16'($urandom); wdata = $urandom;
    cyc = 1; nrd = 0; nwr = 0; addr_ok = 1'b1; busy_ok = 1'b1; fin = 1'b0;
    while (!fin) begin
      if (mem_read === 1'b1) nrd++;
      if (mem_write === 1'b1) nwr++;
      if ((mem_read === 1'b1 || mem_write === 1'b1) && (mem_addr !== {a[15:2], 2'b00})) addr_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1 || cyc >= 8) fin = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    check({name, " done_cycle"}, 32'(cyc), 32'(exp_c));
    check({name, " err"}, 32'(err), 32'(exp_e));
    check({name, " rdata"}, rdata, exp_r);
    check({name, " mem_read_cycles"}, 32'(nrd), 32'(exp_rd));
    check({name, " mem_write_cycles"}, 32'(nwr), 32'(exp_wr));
    check({name, " mem_addr_ok"}, 32'(addr_ok), 32'd1);
    check({name, " busy_held"}, 32'(busy_ok), 32'd1);
    @(negedge clock);
    check({name, " idle_after"}, 32'({busy, done, err}), 32'd0);
  endtask

  initial begin
    logic [31:0] saved, saved8, exp_v;
    bit          seen;
    logic        w, u, t;
    logic [1:0]  sz;
    logic [15:0] a;
    logic [31:0] d;

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    check("reset rdata", rdata, 32'd0);
    check("reset flags", 32'({busy, done, err, mem_read, mem_write}), 32'd0);
    check("reset mem_addr", {16'h0, mem_addr}, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);

    // Directed vector table.
    tbl.push_back('{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 16'h0010, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 16'h0011, 32'h1234_56AA, 32'hDEAD_BEEF, 1'b0, 3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,         32'h1122_AA44, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 16'h0011, 32'h0,         32'hFFFF_FFAA, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 16'h0011, 32'h0,         32'h0000_00AA, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 16'h0012, 32'h5A5A_8001, 32'h0000_00AA, 1'b0, 3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,         32'h8001_AA44, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 16'h0012, 32'h0,         32'hFFFF_8001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 16'h0012, 32'h0,         32'h0000_8001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 16'h0010, 32'h0,         32'h0000_0044, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 16'h0010, 32'h0,         32'hFFFF_AA44, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 16'h0013, 32'h0,         32'hFFFF_FF80, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 16'h0013, 32'h0,         32'h0000_0080, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b11, 1'b1, 16'h0010, 32'h0,         32'h8001_AA44, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 16'h0012, 32'h0,         32'h0000_8001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 16'h0013, 32'h0,
                    TRAP ? 32'h0000_8001 : 32'h8001_AA44, TRAP, TRAP ? 1 : 2});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 16'h0011, 32'h0000_BEEF,
                    TRAP ? 32'h0000_8001 : 32'h8001_AA44, TRAP, TRAP ? 1 : 3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,
                    TRAP ? 32'h8001_AA44 : 32'h8001_BEEF, 1'b0, 2});
    for (int i = 0; i < tbl.size(); i++)
      do_access($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d,
                tbl[i].r, tbl[i].e, tbl[i].c);
    rdata_model = TRAP ? 32'h8001_AA44 : 32'h8001_BEEF;
    check("table final word", tb_mem[4], TRAP ? 32'h8001_AA44 : 32'h8001_BEEF);

    // Reset during the read phase of a byte store: the write must never happen.
    saved = tb_mem[4];
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 16'h0010; wdata = 32'h0000_0055;
    @(negedge clock);
    req = 1'b0;
    check("rmw_rd mem_read", 32'(mem_read), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset flags", 32'({busy, done, err, mem_read, mem_write}), 32'd0);
    check("async reset rdata", rdata, 32'd0);
    check("async reset mem_addr", {16'h0, mem_addr}, 32'd0);
    check("async reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    check("aborted rmw word", tb_mem[4], saved);
    check("aborted rmw idle", 32'({busy, done}), 32'd0);
    rdata_model = 32'h0;

    // A request presented during RESP is ignored.
    exp_v  = ref_load(2'b10, 1'b0, 16'h0010);
    saved8 = tb_mem[8];
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 16'h0010;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    check("resp done", 32'(done), 32'd1);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 16'h0020; wdata = 32'hCAFE_F00D;
    @(negedge clock);
    req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (busy !== 1'b0 || mem_write !== 1'b0) seen = 1'b1;
      @(negedge clock);
    end
    check("resp req ignored", 32'(seen), 32'd0);
    check("resp req no write", tb_mem[8], saved8);
    check("resp load rdata", rdata, exp_v);
    rdata_model = exp_v;

    // Randomized back-to-back accesses against the reference memory.
    for (int k = 0; k < 200; k++) begin
      w  = 1'($urandom);
      sz = 2'($urandom);
      u  = 1'($urandom);
      a  = 16'($urandom) & 16'hFC3F;
      d  = $urandom;
      t  = trap_of(sz, a);
      if (!w && !t) rdata_model = ref_load(sz, u, a);
      do_access($sformatf("rand%0d", k), w, sz, u, a, d, rdata_model, t,
                t ? 1 : ((!w || sz[1]) ? 2 : 3));
      if (w) check($sformatf("rand%0d word", k), tb_mem[a[9:2]], ref_load(2'b10, 1'b0, a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
